// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types for the decode-stage hazard controller: scoreboard entry,
// memory-wait FSM states and register address width.
package pipe_ctrl_pkg;

  localparam int REG_W = 4;

  typedef logic [REG_W-1:0] reg_addr_t;

  typedef struct packed {
    logic      valid;
    logic      wb_en;
    logic      mem_r;
    reg_addr_t dest;
  } sb_entry_t;

  typedef enum logic {
    RUN  = 1'b0,
    WAIT = 1'b1
  } mem_state_t;

  localparam sb_entry_t SB_EMPTY = '0;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Decode-stage hazard interface: ID operand info and memory/branch status in,
// stall/flush controls and status out.
interface pipeline_hazard_ctrl_if #(
  parameter int CNT_W = 16
);

  logic                  id_valid;
  pipe_ctrl_pkg::reg_addr_t id_src1;
  pipe_ctrl_pkg::reg_addr_t id_src2;
  logic                  id_two_src;
  logic                  id_wb_en;
  logic                  id_mem_r_en;
  pipe_ctrl_pkg::reg_addr_t id_dest;
  logic                  mem_op;
  logic                  mem_ready;
  logic                  exe_br_taken;
  logic                  hazard;
  logic                  freeze;
  logic                  mem_freeze;
  logic                  flush;
  logic                  mem_timeout;
  logic [CNT_W-1:0]      stall_cnt;

  modport master (
    output id_valid, id_src1, id_src2, id_two_src, id_wb_en, id_mem_r_en, id_dest,
    output mem_op, mem_ready, exe_br_taken,
    input  hazard, freeze, mem_freeze, flush, mem_timeout, stall_cnt
  );

  modport slave (
    input  id_valid, id_src1, id_src2, id_two_src, id_wb_en, id_mem_r_en, id_dest,
    input  mem_op, mem_ready, exe_br_taken,
    output hazard, freeze, mem_freeze, flush, mem_timeout, stall_cnt
  );

endinterface

// File: rtl/pipeline_hazard_ctrl_compare.sv
// RAW match of one in-flight scoreboard entry against the ID read addresses.
module hazard_compare
  import pipe_ctrl_pkg::*;
(
  input  sb_entry_t entry,
  input  reg_addr_t src1,
  input  reg_addr_t src2,
  input  logic      two_src,
  output logic      match
);

  assign match = entry.valid & entry.wb_en &
                 ((entry.dest == src1) | (two_src & (entry.dest == src2)));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Decode-stage sequencer: EXE/MEM shadow scoreboard, bubble/freeze/flush
// generation, memory-wait FSM with timeout, and saturating stall counter.
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter bit FORWARD_EN = 1'b1,
  parameter int WAIT_LIMIT = 255,
  parameter int CNT_W      = 16
) (
  input logic                   clk,
  input logic                   rst,
  pipeline_hazard_ctrl_if.slave bus
);

  localparam int                WCNT_W    = $clog2(WAIT_LIMIT + 1);
  localparam logic [WCNT_W-1:0] WAIT_MAX  = WCNT_W'(WAIT_LIMIT);
  localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'(WAIT_LIMIT - 1);

  sb_entry_t         exe_q, mem_q, id_entry;
  mem_state_t        state_q, state_d;
  logic [WCNT_W-1:0] wait_cnt_q;
  logic              timeout_q;
  logic [CNT_W-1:0]  stall_cnt_q;
  logic              exe_match, mem_match;
  logic              mem_freeze, flush, hazard, freeze;

  hazard_compare u_cmp_exe (
    .entry   (exe_q),
    .src1    (bus.id_src1),
    .src2    (bus.id_src2),
    .two_src (bus.id_two_src),
    .match   (exe_match)
  );

  hazard_compare u_cmp_mem (
    .entry   (mem_q),
    .src1    (bus.id_src1),
    .src2    (bus.id_src2),
    .two_src (bus.id_two_src),
    .match   (mem_match)
  );

  // NOTE: every signal written here gets a default first, so no path can leave
  // it unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    mem_freeze = 1'b0;
    unique case (state_q)
      RUN: begin
        if (bus.mem_op && !bus.mem_ready) begin
          state_d    = WAIT;
          mem_freeze = 1'b1;
        end
      end
      WAIT: begin
        if (bus.mem_ready) state_d    = RUN;
        else               mem_freeze = 1'b1;
      end
    endcase
  end

  // A taken branch overrides any stall on the instruction it squashes.
  assign flush  = bus.exe_br_taken & ~mem_freeze;
  assign hazard = bus.id_valid & ~flush &
                  (FORWARD_EN ? (exe_match & exe_q.mem_r) : (exe_match | mem_match));
  assign freeze = hazard | mem_freeze;

  assign id_entry = '{valid: 1'b1, wb_en: bus.id_wb_en, mem_r: bus.id_mem_r_en,
                      dest: bus.id_dest};

  // NOTE: non-blocking assignments throughout so every register samples the
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= RUN;
      exe_q       <= SB_EMPTY;
      mem_q       <= SB_EMPTY;
      wait_cnt_q  <= '0;
      timeout_q   <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q <= state_d;

      if (!mem_freeze) begin
        mem_q <= exe_q;
        exe_q <= (bus.id_valid && !hazard && !flush) ? id_entry : SB_EMPTY;
      end

      if (state_q == WAIT) begin
        if (wait_cnt_q != WAIT_MAX)  wait_cnt_q <= wait_cnt_q + 1'b1;
        if (wait_cnt_q == WAIT_LAST) timeout_q  <= 1'b1;
      end else begin
        wait_cnt_q <= '0;
      end

      if (freeze && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

  assign bus.hazard      = hazard;
  assign bus.freeze      = freeze;
  assign bus.mem_freeze  = mem_freeze;
  assign bus.flush       = flush;
  assign bus.mem_timeout = timeout_q;
  assign bus.stall_cnt   = stall_cnt_q;

endmodule
